output_channel_scheduler: RTL and testbench
===========================================

Name: output_channel_scheduler

Overview:
Sequences the channel select of the wavelet output multiplexer. Scans the enabled wavelet filter channels round-robin, presenting each channel for a programmable number of sample strobes, or holds one manually chosen channel. Tags each multiplexed sample with its channel and a frame-start marker. Configuration changes are staged and applied only at frame boundaries so the output stream never carries a partial frame.

Parameters:
NUM_FILTERS, 8, number of wavelet channels (select/tag space)
DWELL_WIDTH, 8, width of the dwell count

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
i_sample_strobe  in  1  wavelet outputs valid this cycle; the mux captures them at this edge
i_cfg_load  in  1  one-cycle pulse: stage the config inputs below
i_scan_mode  in  1  1 = round-robin scan, 0 = manual hold
i_manual_channel  in  8  channel used in manual mode
i_channel_enable  in  NUM_FILTERS  per-channel scan enable
i_dwell  in  DWELL_WIDTH  strobes per channel minus one
o_select_output_channel  out  8  drives the mux channel select
o_valid  out  1  mux output holds a fresh sample this cycle
o_channel_tag  out  8  channel of the sample flagged by o_valid
o_frame_start  out  1  qualifies o_valid: first sample of a frame
o_cfg_pending  out  1  staged config is waiting for a frame boundary
o_busy  out  1  state == DWELL

Behaviour:
- Reset (asynchronous, immediate): state IDLE. All outputs are 0. Active config and staged config are cleared (enable = 0, dwell = 0, manual = 0, mode = manual).
- Config load:
  - A cycle with i_cfg_load high copies all four config inputs into the staging registers.
  - In IDLE, staging is applied to the active config at the next edge.
  - In DWELL, o_cfg_pending is set and the staged config is applied at the next frame boundary.
  - A new load while pending overwrites staging; the latest values win.
  - A load in the same cycle as a boundary applies the new input values at that boundary.
- States: IDLE and DWELL.
  - IDLE → DWELL when the active config is manual mode, or scan mode with enable != 0. On that edge, select is loaded with the first channel and the dwell counter is cleared.
  - DWELL → IDLE at a boundary where the newly applied config is scan mode with enable == 0. Select holds its last value.
- First channel:
  - Scan mode: the lowest enabled index.
  - Manual mode: i_manual_channel. A value ≥ NUM_FILTERS forces select = 0.
- Accepted strobe: i_sample_strobe high while state == DWELL. Strobes in IDLE are ignored and produce no o_valid.
- Output latency: one cycle. The cycle after an accepted strobe, o_valid = 1 and o_channel_tag = the select value in the strobe cycle. This matches the mux register latency.
- Dwell counter:
  - Increments on each accepted strobe.
  - When the count equals the active dwell on an accepted strobe, the counter clears and select advances at that same edge. The mux has already captured using the old select at that edge.
  - Each channel therefore yields dwell+1 samples. dwell = 0 gives one sample per channel.
- Advance (scan mode): select moves to the lowest enabled index strictly greater than the current one. If none exists, it wraps to the lowest enabled index, and that wrap is a frame boundary.
  - Single enabled channel: every advance is a wrap.
  - Channels disabled by a newly applied config are never selected after the boundary.
- Advance (manual mode): select is unchanged, and every dwell completion is a frame boundary.
- o_frame_start is asserted together with o_valid for the first accepted strobe:
  - after IDLE → DWELL, and
  - after every frame boundary.
- At a boundary with pending config: active config is updated and o_cfg_pending clears on that edge. The next select is computed from the new config.
- o_valid, o_frame_start and o_channel_tag are registered. o_channel_tag holds its value when o_valid is low.

Test Plan:
- Reset then load scan, enable = 8'b0000_0101, dwell = 0; strobe every 4 cycles → tags 0, 2, 0, 2…; o_frame_start on every tag-0 sample; select changes on each strobe edge.
- Scan, enable = 8'hFF, dwell = 2; continuous strobes → each tag repeated 3×, 0 through 7 then wrap; o_valid trails each strobe by exactly 1 cycle.
- Mid-frame load of enable = 8'h80 while on channel 2 → o_cfg_pending = 1 until the wrap; remaining channels 3–7 still served; then only tag 7 appears, with frame_start on each sample.
- Manual mode, manual = 9, dwell = 1 → select = 0, tags 0; frame_start on every 2nd sample. Then load manual = 5 → takes effect after the current dwell completes.
- Load scan with enable = 0 while DWELL → at the boundary the block returns to IDLE, o_busy = 0; later strobes give no o_valid.
- Assert rst asynchronously mid-dwell in the cycle after a strobe → o_valid and all outputs drop to 0 before the next clock edge; after release the block stays IDLE with no o_valid until a new i_cfg_load.

Source files
------------

// File: rtl/output_channel_scheduler.sv
// Channel-select sequencer for the wavelet output mux: round-robin scan or manual hold,
// with per-sample channel tags and frame-start markers; config changes land only on frame boundaries.
module output_channel_scheduler #(
  parameter int NUM_FILTERS = 8,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_sample_strobe,
  input  logic                   i_cfg_load,
  input  logic                   i_scan_mode,
  input  logic [7:0]             i_manual_channel,
  input  logic [NUM_FILTERS-1:0] i_channel_enable,
  input  logic [DWELL_WIDTH-1:0] i_dwell,
  output logic [7:0]             o_select_output_channel,
  output logic                   o_valid,
  output logic [7:0]             o_channel_tag,
  output logic                   o_frame_start,
  output logic                   o_cfg_pending,
  output logic                   o_busy
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t                 r_state;
  logic                   r_act_scan, r_stg_scan;
  logic [7:0]             r_act_man, r_stg_man;
  logic [NUM_FILTERS-1:0] r_act_en, r_stg_en;
  logic [DWELL_WIDTH-1:0] r_act_dwell, r_stg_dwell;
  logic                   r_pend;
  logic [DWELL_WIDTH-1:0] r_cnt;
  logic [7:0]             r_sel;
  logic                   r_first;
  logic                   r_valid;
  logic [7:0]             r_tag;
  logic                   r_fs;

  logic                   w_new_scan;
  logic [7:0]             w_new_man;
  logic [NUM_FILTERS-1:0] w_new_en;
  logic [DWELL_WIDTH-1:0] w_new_dwell;
  logic                   w_has_next;
  logic [7:0]             w_next;
  logic                   w_accept, w_done, w_boundary;

  function automatic logic [7:0] f_first(input logic scan, input logic [7:0] man,
                                         input logic [NUM_FILTERS-1:0] en);
    logic [7:0] ch;
    ch = '0;
    if (scan) begin
      for (int i = NUM_FILTERS - 1; i >= 0; i--)
        if (en[i]) ch = 8'(i);
    end else if (32'(man) < NUM_FILTERS) begin
      ch = man;
    end
    return ch;
  endfunction

  // A load coinciding with a boundary wins over whatever is staged.
  always_comb begin
    w_new_scan  = r_act_scan;
    w_new_man   = r_act_man;
    w_new_en    = r_act_en;
    w_new_dwell = r_act_dwell;
    if (i_cfg_load) begin
      w_new_scan  = i_scan_mode;
      w_new_man   = i_manual_channel;
      w_new_en    = i_channel_enable;
      w_new_dwell = i_dwell;
    end else if (r_pend) begin
      w_new_scan  = r_stg_scan;
      w_new_man   = r_stg_man;
      w_new_en    = r_stg_en;
      w_new_dwell = r_stg_dwell;
    end
  end

  always_comb begin
    w_has_next = 1'b0;
    w_next     = '0;
    for (int i = NUM_FILTERS - 1; i >= 0; i--) begin
      if (r_act_en[i] && (8'(i) > r_sel)) begin
        w_has_next = 1'b1;
        w_next     = 8'(i);
      end
    end
  end

  assign w_accept   = i_sample_strobe && (r_state == DWELL);
  assign w_done     = w_accept && (r_cnt == r_act_dwell);
  assign w_boundary = w_done && (!r_act_scan || !w_has_next);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_act_scan  <= 1'b0;
      r_act_man   <= '0;
      r_act_en    <= '0;
      r_act_dwell <= '0;
      r_stg_scan  <= 1'b0;
      r_stg_man   <= '0;
      r_stg_en    <= '0;
      r_stg_dwell <= '0;
      r_pend      <= 1'b0;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_first     <= 1'b0;
      r_valid     <= 1'b0;
      r_tag       <= '0;
      r_fs        <= 1'b0;
    end else begin
      r_valid <= w_accept;
      r_fs    <= w_accept && r_first;
      if (w_accept) r_tag <= r_sel;
      if (i_cfg_load) begin
        r_stg_scan  <= i_scan_mode;
        r_stg_man   <= i_manual_channel;
        r_stg_en    <= i_channel_enable;
        r_stg_dwell <= i_dwell;
      end
      case (r_state)
        IDLE: begin
          r_pend <= i_cfg_load;
          if (r_pend) begin
            r_act_scan  <= r_stg_scan;
            r_act_man   <= r_stg_man;
            r_act_en    <= r_stg_en;
            r_act_dwell <= r_stg_dwell;
            if (!r_stg_scan || (r_stg_en != '0)) begin
              r_state <= DWELL;
              r_sel   <= f_first(r_stg_scan, r_stg_man, r_stg_en);
              r_cnt   <= '0;
              r_first <= 1'b1;
            end
          end
        end
        DWELL: begin
          if (i_cfg_load) r_pend <= 1'b1;
          if (w_accept) begin
            r_first <= 1'b0;
            if (!w_done) begin
              r_cnt <= r_cnt + 1'b1;
            end else begin
              r_cnt <= '0;
              if (!w_boundary) begin
                r_sel <= w_next;
              end else begin
                r_act_scan  <= w_new_scan;
                r_act_man   <= w_new_man;
                r_act_en    <= w_new_en;
                r_act_dwell <= w_new_dwell;
                r_pend      <= 1'b0;
                r_first     <= 1'b1;
                if (w_new_scan && (w_new_en == '0)) r_state <= IDLE;
                else r_sel <= f_first(w_new_scan, w_new_man, w_new_en);
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_select_output_channel = r_sel;
  assign o_valid                 = r_valid;
  assign o_channel_tag           = r_tag;
  assign o_frame_start           = r_fs;
  assign o_cfg_pending           = r_pend && (r_state == DWELL);
  assign o_busy                  = (r_state == DWELL);

endmodule

// File: tb/tb_output_channel_scheduler.sv
// Directed bench for output_channel_scheduler: scan, mid-frame reconfig, manual hold,
// return to idle and asynchronous reset, all against hand-derived tag/select sequences.
module tb_output_channel_scheduler;

  logic       clk;
  logic       rst;
  logic       i_sample_strobe;
  logic       i_cfg_load;
  logic       i_scan_mode;
  logic [7:0] i_manual_channel;
  logic [7:0] i_channel_enable;
  logic [7:0] i_dwell;
  logic [7:0] o_select_output_channel;
  logic       o_valid;
  logic [7:0] o_channel_tag;
  logic       o_frame_start;
  logic       o_cfg_pending;
  logic       o_busy;

  int n_cmp = 0;
  int n_err = 0;

  output_channel_scheduler #(.NUM_FILTERS(8), .DWELL_WIDTH(8)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .i_sample_strobe         (i_sample_strobe),
    .i_cfg_load              (i_cfg_load),
    .i_scan_mode             (i_scan_mode),
    .i_manual_channel        (i_manual_channel),
    .i_channel_enable        (i_channel_enable),
    .i_dwell                 (i_dwell),
    .o_select_output_channel (o_select_output_channel),
    .o_valid                 (o_valid),
    .o_channel_tag           (o_channel_tag),
    .o_frame_start           (o_frame_start),
    .o_cfg_pending           (o_cfg_pending),
    .o_busy                  (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic load(input logic scan, input logic [7:0] man, input logic [7:0] en,
                      input logic [7:0] dw);
    i_cfg_load       = 1'b1;
    i_scan_mode      = scan;
    i_manual_channel = man;
    i_channel_enable = en;
    i_dwell          = dw;
    tick();
    i_cfg_load = 1'b0;
  endtask

  task automatic strobe(input int exp_tag, input int exp_fs, input int exp_sel);
    i_sample_strobe = 1'b1;
    tick();
    i_sample_strobe = 1'b0;
    chk("valid", 32'(o_valid), 1);
    chk("tag", 32'(o_channel_tag), 32'(exp_tag));
    chk("frame_start", 32'(o_frame_start), 32'(exp_fs));
    chk("select", 32'(o_select_output_channel), 32'(exp_sel));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    i_sample_strobe = 1'b0;
    i_cfg_load = 1'b0;
    i_scan_mode = 1'b0;
    i_manual_channel = '0;
    i_channel_enable = '0;
    i_dwell = '0;
    @(negedge clk);
    do_reset();
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_select", 32'(o_select_output_channel), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_pending", 32'(o_cfg_pending), 0);

    // Scan over channels 0 and 2, one sample each, strobe every 4 cycles
    load(1'b1, 8'd0, 8'b0000_0101, 8'd0);
    chk("idle_before_apply", 32'(o_busy), 0);
    tick();
    chk("busy_after_load", 32'(o_busy), 1);
    chk("first_select", 32'(o_select_output_channel), 0);
    for (int k = 0; k < 4; k++) begin
      strobe((k % 2) * 2, (k % 2 == 0) ? 1 : 0, ((k + 1) % 2) * 2);
      tick();
      chk("valid_gap", 32'(o_valid), 0);
      tick();
      tick();
    end

    // All channels, dwell 2, continuous strobes; then mid-frame reconfig to channel 7 only
    do_reset();
    load(1'b1, 8'd0, 8'hFF, 8'd2);
    tick();
    chk("valid_before_strobe", 32'(o_valid), 0);
    for (int k = 0; k < 32; k++)
      strobe((k / 3) % 8, (k % 24 == 0) ? 1 : 0, ((k + 1) / 3) % 8);
    load(1'b1, 8'd0, 8'h80, 8'd0);
    chk("pending_set", 32'(o_cfg_pending), 1);
    chk("valid_after_stop", 32'(o_valid), 0);
    for (int k = 32; k < 47; k++)
      strobe((k / 3) % 8, 0, ((k + 1) / 3) % 8);
    chk("pending_held", 32'(o_cfg_pending), 1);
    strobe(7, 0, 7);
    chk("pending_cleared", 32'(o_cfg_pending), 0);
    for (int k = 0; k < 3; k++) strobe(7, 1, 7);

    // Manual hold with out-of-range channel, then manual 5 staged mid-dwell
    do_reset();
    load(1'b0, 8'd9, 8'h00, 8'd1);
    tick();
    chk("manual_busy", 32'(o_busy), 1);
    chk("manual_clamp", 32'(o_select_output_channel), 0);
    for (int k = 0; k < 4; k++) strobe(0, (k % 2 == 0) ? 1 : 0, 0);
    strobe(0, 1, 0);
    load(1'b0, 8'd5, 8'h00, 8'd1);
    chk("manual_pending", 32'(o_cfg_pending), 1);
    chk("manual_sel_held", 32'(o_select_output_channel), 0);
    strobe(0, 0, 5);
    chk("manual_pending_clr", 32'(o_cfg_pending), 0);
    strobe(5, 1, 5);
    strobe(5, 0, 5);
    strobe(5, 1, 5);

    // Scan with nothing enabled: back to IDLE at the boundary
    load(1'b1, 8'd0, 8'h00, 8'd0);
    chk("idle_pending", 32'(o_cfg_pending), 1);
    strobe(5, 0, 5);
    chk("idle_busy", 32'(o_busy), 0);
    chk("idle_pending_clr", 32'(o_cfg_pending), 0);
    i_sample_strobe = 1'b1;
    tick();
    tick();
    i_sample_strobe = 1'b0;
    chk("idle_no_valid", 32'(o_valid), 0);
    chk("idle_tag_hold", 32'(o_channel_tag), 5);
    chk("idle_sel_hold", 32'(o_select_output_channel), 5);

    // Asynchronous reset in the cycle after a strobe
    do_reset();
    load(1'b1, 8'd0, 8'hFF, 8'd3);
    tick();
    strobe(0, 1, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_valid", 32'(o_valid), 0);
    chk("async_fs", 32'(o_frame_start), 0);
    chk("async_busy", 32'(o_busy), 0);
    chk("async_tag", 32'(o_channel_tag), 0);
    @(negedge clk);
    rst = 1'b0;
    i_sample_strobe = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_valid", 32'(o_valid), 0);
      chk("post_rst_busy", 32'(o_busy), 0);
    end
    i_sample_strobe = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
